cmpacc_multi: RTL and testbench
===============================

# cmpacc_multi

Parametrised template-matching accelerator, the multi-template successor to the single bitmap compare accelerator. It holds NTMPL stored glyph templates, each HEIGHT×WIDTH bits, in an internal column-organised store. On `start` it captures one input bitmap and scores it against every template, one column per cycle, in either match-count or ink-overlap mode. It reports the best template index and its score with a one-cycle `done` pulse, and sits between the bitmap extraction stage and the symbol classifier.

## Interface
- `HEIGHT`, default 64, bits per column (pixel rows).
- `WIDTH`, default 24, columns per bitmap.
- `NTMPL`, default 8, number of stored templates (≥2).
- Derived:
  - IDX_W = $clog2(NTMPL)
  - COL_W = $clog2(WIDTH)
  - SCORE_W = $clog2(HEIGHT*WIDTH+1), which is 11 at the defaults.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a compare; honoured only in IDLE.
- `mode` in 1: 0 = match count (XNOR), 1 = overlap count (AND); captured with `start`.
- `bitmap` in HEIGHT*WIDTH: input image. Column c is `bitmap[c*HEIGHT +: HEIGHT]`. Captured with `start`.
- `tmpl_we` in 1: template column write strobe.
- `tmpl_idx` in IDX_W: template being written.
- `tmpl_col` in COL_W: column being written; values ≥ WIDTH are ignored.
- `tmpl_data` in HEIGHT: column data.
- `busy` out 1: high from the cycle after an accepted `start` through the last RUN cycle.
- `done` out 1: one-cycle pulse; results are valid in that cycle.
- `best_idx` out IDX_W: winning template.
- `best_score` out SCORE_W: score of the winning template.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 → capture `bitmap` and `mode`; set t=0, c=0, acc=0, best_score=0, best_idx=0; go to RUN.
  - Template writes are accepted: store[tmpl_idx][tmpl_col] ← tmpl_data.
- **RUN**, one column per cycle:
  - Per-column term: p = popcount(mode ? bmp_col[c] & tmpl[t][c] : ~(bmp_col[c] ^ tmpl[t][c])).
  - c < WIDTH-1: acc ← acc + p; c ← c+1.
  - c = WIDTH-1: form s = acc + p.
    - If s > best_score (strict), then best_score ← s and best_idx ← t.
    - Then acc ← 0, c ← 0, t ← t+1.
  - After the last column of template NTMPL-1, go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then return to IDLE.
- Ties keep the lowest index. If all scores are 0, the result is idx 0, score 0.
- `best_idx` and `best_score` hold their values until the next accepted `start` clears them. The clear is visible in the first RUN cycle.
- `start` while in RUN or DONE is ignored; it is not queued.
- `tmpl_we` while in RUN or DONE is dropped, so templates stay coherent during a compare.
- Accumulator width is SCORE_W; overflow cannot occur by construction.

## Timing
- Accepted `start` sampled at edge k:
  - RUN occupies cycles k..k+NTMPL*WIDTH-1.
  - `done` is high in cycle k+NTMPL*WIDTH.
  - At the defaults the latency is 192 cycles from the `start` edge to `done`.
- `busy` is low in the DONE cycle. A new `start` is accepted in the DONE cycle's following IDLE cycle at the earliest.
- A template write is visible to a compare started on the next edge or later.
- Reset (`rst_n`=0 at an edge):
  - FSM → IDLE.
  - `busy`, `done`, `best_idx`, `best_score`, acc, t and c all go to 0.
  - Reset mid-RUN aborts the compare with no `done`.
  - The template store is NOT reset; its contents are undefined after power-up until written.

## Structure
- Shared package `cmpacc_pkg`:
  - FSM state encoding (IDLE=0, RUN=1, DONE=2).
  - `mode` constants MODE_MATCH=0 and MODE_OVERLAP=1.
  - A clog2 helper for the derived widths.
- Sub-module `popcount #(.W(HEIGHT))`: combinational population count with a $clog2(W+1)-bit output, instantiated once.
- The template store is a register array, NTMPL*WIDTH entries of HEIGHT bits, read by {t,c}.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → `busy`=0, `done`=0, `best_idx`=0, `best_score`=0.
- **Exact match:** defaults; load templates 0–7 with all-zero except template 3 = checkerboard. `bitmap` = same checkerboard, `mode`=0, `start` at edge k → `done` only at k+192, `best_idx`=3, `best_score`=1536.
- **Overlap mode:** `bitmap` all ones; template t has columns 0..t all ones, rest zero; `mode`=1 → `best_idx`=7, `best_score`=512.
- **Tie rule:** all templates identical, any bitmap, `mode`=0 → `best_idx`=0, `best_score` equal to the common score.
- **Protocol:**
  - Pulse `start` and `tmpl_we` mid-RUN → ignored; the result is unchanged versus a clean run.
  - Assert `rst_n`=0 at RUN cycle 50 → `busy`=0 next cycle, no `done`, outputs 0, templates retained (a rerun gives the correct result).
- **Parameter variant:** HEIGHT=8, WIDTH=4, NTMPL=2; template 1 = input bitmap, template 0 = its inverse, `mode`=0 → `done` 8 cycles after `start`, `best_idx`=1, `best_score`=32.

Source files
------------

// File: rtl/cmpacc_multi_pkg.sv
// ---------------------------------------------------------------------------
// cmpacc_pkg
// Shared definitions for the multi-template compare accelerator:
//   state_e       - controller states (IDLE=0, RUN=1, DONE=2)
//   MODE_MATCH    - score by counting agreeing pixels (XNOR)
//   MODE_OVERLAP  - score by counting pixels inked in both images (AND)
//   clog2         - ceiling log2, used to size derived buses
//   index_width   - clog2 with a floor of one bit, for counters and indices
// ---------------------------------------------------------------------------
package cmpacc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_MATCH   = 1'b0;
  localparam logic MODE_OVERLAP = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A one-entry range still needs a one-bit select line.
  function automatic int index_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/cmpacc_multi_if.sv
// ---------------------------------------------------------------------------
// cmpacc_multi_if
// Bundle of request, template-load and result signals for cmpacc_multi.
//   start/mode/bitmap                       - compare request
//   tmpl_we/tmpl_idx/tmpl_col/tmpl_data     - template column write port
//   busy/done/best_idx/best_score           - status and result
// modport master: the requesting side (bitmap extractor / bench)
// modport slave : the accelerator
// ---------------------------------------------------------------------------
interface cmpacc_multi_if
  import cmpacc_pkg::*;
#(
  parameter int HEIGHT = 64,
  parameter int WIDTH  = 24,
  parameter int NTMPL  = 8
);

  localparam int IDX_W   = index_width(NTMPL);
  localparam int COL_W   = index_width(WIDTH);
  localparam int SCORE_W = clog2(HEIGHT * WIDTH + 1);

  logic                      start;
  logic                      mode;
  logic [HEIGHT*WIDTH-1:0]   bitmap;
  logic                      tmpl_we;
  logic [IDX_W-1:0]          tmpl_idx;
  logic [COL_W-1:0]          tmpl_col;
  logic [HEIGHT-1:0]         tmpl_data;
  logic                      busy;
  logic                      done;
  logic [IDX_W-1:0]          best_idx;
  logic [SCORE_W-1:0]        best_score;

  modport master (
    output start, mode, bitmap, tmpl_we, tmpl_idx, tmpl_col, tmpl_data,
    input  busy, done, best_idx, best_score
  );

  modport slave (
    input  start, mode, bitmap, tmpl_we, tmpl_idx, tmpl_col, tmpl_data,
    output busy, done, best_idx, best_score
  );

endinterface

// File: rtl/cmpacc_multi_popcount.sv
// ---------------------------------------------------------------------------
// popcount
// Combinational population count.
//   bits  [W-1:0]            - input vector
//   count [clog2(W+1)-1:0]   - number of ones in bits
// ---------------------------------------------------------------------------
module popcount
  import cmpacc_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0]            bits,
  output logic [clog2(W+1)-1:0]   count
);

  localparam int CW = clog2(W + 1);

  // Plain adder chain; synthesis rebuilds it as a balanced tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/cmpacc_multi.sv
// ---------------------------------------------------------------------------
// cmpacc_multi
// Scores one captured bitmap against NTMPL stored templates, one column per
// cycle, and reports the best-scoring template with a one-cycle done pulse.
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (template store is not reset)
//   bus    - cmpacc_multi_if.slave: start/mode/bitmap request, template
//            write port, busy/done/best_idx/best_score results
// ---------------------------------------------------------------------------
module cmpacc_multi
  import cmpacc_pkg::*;
#(
  parameter int HEIGHT = 64,
  parameter int WIDTH  = 24,
  parameter int NTMPL  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  cmpacc_multi_if.slave  bus
);

  localparam int IDX_W   = index_width(NTMPL);
  localparam int COL_W   = index_width(WIDTH);
  localparam int SCORE_W = clog2(HEIGHT * WIDTH + 1);
  localparam int PC_W    = clog2(HEIGHT + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] TMPL_LAST = IDX_W'(NTMPL - 1);

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]      best_score_q, best_score_d;
  logic [SCORE_W-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]        t_q, t_d;
  logic [COL_W-1:0]        c_q, c_d;
  logic                    mode_q, mode_d;
  logic [HEIGHT*WIDTH-1:0] bmp_q, bmp_d;

  logic [HEIGHT-1:0]       store_q [NTMPL][WIDTH];
  logic                    store_we;

  logic [HEIGHT-1:0]       bmp_col;
  logic [HEIGHT-1:0]       tmpl_col_data;
  logic [HEIGHT-1:0]       pc_in;
  logic [PC_W-1:0]         pc_count;
  logic [SCORE_W-1:0]      col_sum;

  // Template writes are only taken while idle so a compare always sees one
  // consistent set of templates; out-of-range indices are dropped.
  always_comb begin
    store_we = bus.tmpl_we
            && (state_q == ST_IDLE)
            && (int'(bus.tmpl_col) < WIDTH)
            && (int'(bus.tmpl_idx) < NTMPL);
  end

  // Template store: plain register array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[bus.tmpl_idx][bus.tmpl_col] <= bus.tmpl_data;
    end
  end

  // Column datapath: pick column c of the captured bitmap and of template t,
  // combine them according to the captured mode, and add the column's
  // popcount to the running template score.
  always_comb begin
    bmp_col       = bmp_q[int'(c_q) * HEIGHT +: HEIGHT];
    tmpl_col_data = store_q[t_q][c_q];
    if (mode_q == MODE_OVERLAP) begin
      pc_in = bmp_col & tmpl_col_data;
    end else begin
      pc_in = ~(bmp_col ^ tmpl_col_data);
    end
  end

  popcount #(.W(HEIGHT)) u_popcount (
    .bits  (pc_in),
    .count (pc_count)
  );

  always_comb begin
    col_sum = acc_q + SCORE_W'(pc_count);
  end

  // Controller next-state logic. A strict greater-than on the final template
  // score keeps the lowest index on ties and leaves idx 0 / score 0 when
  // nothing scores at all.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    acc_d        = acc_q;
    t_d          = t_q;
    c_d          = c_q;
    mode_d       = mode_q;
    bmp_d        = bmp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          bmp_d        = bus.bitmap;
          mode_d       = bus.mode;
          t_d          = '0;
          c_d          = '0;
          acc_d        = '0;
          best_score_d = '0;
          best_idx_d   = '0;
          busy_d       = 1'b1;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (c_q == COL_LAST) begin
          if (col_sum > best_score_q) begin
            best_score_d = col_sum;
            best_idx_d   = t_q;
          end
          acc_d = '0;
          c_d   = '0;
          if (t_q == TMPL_LAST) begin
            t_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            t_d = t_q + IDX_W'(1);
          end
        end else begin
          acc_d = col_sum;
          c_d   = c_q + COL_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller and result registers, all cleared by reset so an aborted
  // compare leaves clean outputs and never pulses done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      acc_q        <= '0;
      t_q          <= '0;
      c_q          <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      acc_q        <= acc_d;
      t_q          <= t_d;
      c_q          <= c_d;
    end
  end

  // Captured request; only meaningful while RUN, so no reset is needed.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    bmp_q  <= bmp_d;
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best_idx   = best_idx_q;
  assign bus.best_score = best_score_q;

endmodule

// File: tb/tb_cmpacc_multi.sv
// ---------------------------------------------------------------------------
// tb_cmpacc_multi
// Self-checking bench for cmpacc_multi: a default-size instance and a
// HEIGHT=8/WIDTH=4/NTMPL=2 instance. Expected results are queued when a
// compare is started and checked when done pulses.
// ---------------------------------------------------------------------------
module tb_cmpacc_multi;

  localparam int H0 = 64;
  localparam int W0 = 24;
  localparam int N0 = 8;
  localparam int LAT0 = N0 * W0;

  localparam int H1 = 8;
  localparam int W1 = 4;
  localparam int N1 = 2;
  localparam int LAT1 = N1 * W1;

  typedef struct {
    int  idx;
    int  score;
    int  lat;
    time startTime;
  } expect_t;

  logic clk;
  logic rst_n;

  int checkCount = 0;
  int errorCount = 0;

  expect_t sb0[$];
  expect_t sb1[$];

  logic [H0-1:0] tmplModel [N0][W0];

  cmpacc_multi_if #(.HEIGHT(H0), .WIDTH(W0), .NTMPL(N0)) bus0 ();
  cmpacc_multi_if #(.HEIGHT(H1), .WIDTH(W1), .NTMPL(N1)) bus1 ();

  cmpacc_multi #(.HEIGHT(H0), .WIDTH(W0), .NTMPL(N0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  cmpacc_multi #(.HEIGHT(H1), .WIDTH(W1), .NTMPL(N1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [H0-1:0] checkerCol(input int c);
    logic [H0-1:0] even;
    logic [H0-1:0] odd;
    even = {32{2'b01}};
    odd  = {32{2'b10}};
    return (c % 2 == 0) ? even : odd;
  endfunction

  function automatic logic [H0-1:0] randCol();
    return {$urandom, $urandom};
  endfunction

  // Reference score computed straight from the template model.
  function automatic void modelBest(input logic modeIn, input logic [H0*W0-1:0] bmp,
                                    output int bestIdx, output int bestScore);
    int s;
    logic [H0-1:0] b;
    logic [H0-1:0] tc;
    bestIdx = 0;
    bestScore = 0;
    for (int t = 0; t < N0; t++) begin
      s = 0;
      for (int c = 0; c < W0; c++) begin
        b  = bmp[c*H0 +: H0];
        tc = tmplModel[t][c];
        s += modeIn ? $countones(b & tc) : $countones(~(b ^ tc));
      end
      if (s > bestScore) begin
        bestScore = s;
        bestIdx = t;
      end
    end
  endfunction

  task automatic writeTemplate(input int idx, input int col, input logic [H0-1:0] data,
                               input bit updateModel);
    #1;
    bus0.tmpl_we   = 1'b1;
    bus0.tmpl_idx  = 3'(idx);
    bus0.tmpl_col  = 5'(col);
    bus0.tmpl_data = data;
    if (updateModel) tmplModel[idx][col] = data;
    @(posedge clk);
    #1;
    bus0.tmpl_we = 1'b0;
  endtask

  task automatic writeTemplateSmall(input int idx, input int col, input logic [H1-1:0] data);
    #1;
    bus1.tmpl_we   = 1'b1;
    bus1.tmpl_idx  = 1'(idx);
    bus1.tmpl_col  = 2'(col);
    bus1.tmpl_data = data;
    @(posedge clk);
    #1;
    bus1.tmpl_we = 1'b0;
  endtask

  // Drive one start pulse on the default-size instance and, if a result is
  // expected, queue it together with the edge time it was accepted on.
  task automatic applyStimulus(input logic modeIn, input logic [H0*W0-1:0] bmp,
                               input int eIdx, input int eScore, input bit expectDone);
    expect_t e;
    #1;
    bus0.mode   = modeIn;
    bus0.bitmap = bmp;
    bus0.start  = 1'b1;
    @(posedge clk);
    if (expectDone) begin
      e.idx = eIdx;
      e.score = eScore;
      e.lat = LAT0;
      e.startTime = $time;
      sb0.push_back(e);
    end
    #1;
    bus0.start = 1'b0;
    checkOutput("busy_first_run", 32'(bus0.busy), 32'd1);
    checkOutput("done_first_run", 32'(bus0.done), 32'd0);
    checkOutput("score_cleared", 32'(bus0.best_score), 32'd0);
    checkOutput("idx_cleared", 32'(bus0.best_idx), 32'd0);
  endtask

  task automatic applySmall(input logic modeIn, input logic [H1*W1-1:0] bmp,
                            input int eIdx, input int eScore);
    expect_t e;
    #1;
    bus1.mode   = modeIn;
    bus1.bitmap = bmp;
    bus1.start  = 1'b1;
    @(posedge clk);
    e.idx = eIdx;
    e.score = eScore;
    e.lat = LAT1;
    e.startTime = $time;
    sb1.push_back(e);
    #1;
    bus1.start = 1'b0;
  endtask

  task automatic waitIdle0(input int budget);
    int n;
    n = 0;
    while (sb0.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb0.size() != 0) begin
      checkOutput("timeout_dut0", 32'(n), 32'(budget - 1));
      sb0.delete();
    end
  endtask

  task automatic waitIdle1(input int budget);
    int n;
    n = 0;
    while (sb1.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb1.size() != 0) begin
      checkOutput("timeout_dut1", 32'(n), 32'(budget - 1));
      sb1.delete();
    end
  endtask

  // Scoreboard for the default-size instance: every done must match the
  // oldest queued expectation, including its latency from the start edge.
  expect_t e0;
  always @(negedge clk) begin
    if (bus0.done) begin
      if (sb0.size() == 0) begin
        checkOutput("unexpected_done0", 32'd1, 32'd0);
      end else begin
        e0 = sb0.pop_front();
        checkOutput("best_idx0", 32'(bus0.best_idx), 32'(e0.idx));
        checkOutput("best_score0", 32'(bus0.best_score), 32'(e0.score));
        checkOutput("latency0", 32'(($time - 5 - e0.startTime) / 10), 32'(e0.lat));
        checkOutput("busy_in_done0", 32'(bus0.busy), 32'd0);
      end
    end
  end

  expect_t e1;
  always @(negedge clk) begin
    if (bus1.done) begin
      if (sb1.size() == 0) begin
        checkOutput("unexpected_done1", 32'd1, 32'd0);
      end else begin
        e1 = sb1.pop_front();
        checkOutput("best_idx1", 32'(bus1.best_idx), 32'(e1.idx));
        checkOutput("best_score1", 32'(bus1.best_score), 32'(e1.score));
        checkOutput("latency1", 32'(($time - 5 - e1.startTime) / 10), 32'(e1.lat));
        checkOutput("busy_in_done1", 32'(bus1.busy), 32'd0);
      end
    end
  end

  // Main sequence.
  initial begin
    logic [H0*W0-1:0] bmp;
    logic [H0-1:0]    col;
    logic [H1*W1-1:0] sbmp;
    logic [H1-1:0]    scol;
    int eIdx;
    int eScore;

    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.mode = 1'b0; bus0.bitmap = '0;
    bus0.tmpl_we = 1'b0; bus0.tmpl_idx = '0; bus0.tmpl_col = '0; bus0.tmpl_data = '0;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.bitmap = '0;
    bus1.tmpl_we = 1'b0; bus1.tmpl_idx = '0; bus1.tmpl_col = '0; bus1.tmpl_data = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus0.busy), 32'd0);
    checkOutput("rst_done", 32'(bus0.done), 32'd0);
    checkOutput("rst_idx", 32'(bus0.best_idx), 32'd0);
    checkOutput("rst_score", 32'(bus0.best_score), 32'd0);
    checkOutput("rst_busy1", 32'(bus1.busy), 32'd0);
    checkOutput("rst_score1", 32'(bus1.best_score), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // Exact match: template 3 is a checkerboard, the rest are blank.
    for (int t = 0; t < N0; t++)
      for (int c = 0; c < W0; c++)
        writeTemplate(t, c, (t == 3) ? checkerCol(c) : '0, 1'b1);
    // Column indices past the bitmap must be ignored.
    for (int c = W0; c < 32; c++) writeTemplate(3, c, '0, 1'b0);
    for (int c = 0; c < W0; c++) bmp[c*H0 +: H0] = checkerCol(c);
    $display("[TB] exact match run");
    applyStimulus(1'b0, bmp, 3, 1536, 1'b1);
    waitIdle0(400);

    // Stray start and template write during RUN must not disturb the result.
    $display("[TB] mid-run start and write run");
    applyStimulus(1'b0, bmp, 3, 1536, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    bus0.start = 1'b1; bus0.mode = 1'b1;
    bus0.tmpl_we = 1'b1; bus0.tmpl_idx = 3'd3; bus0.tmpl_col = 5'd0; bus0.tmpl_data = '0;
    @(posedge clk);
    #1;
    bus0.start = 1'b0; bus0.tmpl_we = 1'b0;
    waitIdle0(400);
    applyStimulus(1'b0, bmp, 3, 1536, 1'b1);
    waitIdle0(400);

    // Overlap mode: template t inked in columns 0..t.
    for (int t = 0; t < N0; t++)
      for (int c = 0; c < W0; c++)
        writeTemplate(t, c, (c <= t) ? {H0{1'b1}} : '0, 1'b1);
    bmp = '1;
    $display("[TB] overlap run");
    applyStimulus(1'b1, bmp, 7, 512, 1'b1);
    waitIdle0(400);

    // Reset during RUN cycle 50 aborts without a done pulse.
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, bmp, 0, 0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(bus0.busy), 32'd0);
    checkOutput("abort_done", 32'(bus0.done), 32'd0);
    checkOutput("abort_idx", 32'(bus0.best_idx), 32'd0);
    checkOutput("abort_score", 32'(bus0.best_score), 32'd0);
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    applyStimulus(1'b1, bmp, 7, 512, 1'b1);
    waitIdle0(400);

    // Tie rule: identical templates, the lowest index wins.
    for (int c = 0; c < W0; c++) begin
      col = randCol();
      for (int t = 0; t < N0; t++) writeTemplate(t, c, col, 1'b1);
    end
    for (int c = 0; c < W0; c++) bmp[c*H0 +: H0] = randCol();
    modelBest(1'b0, bmp, eIdx, eScore);
    $display("[TB] tie run, common score %0d", eScore);
    checkOutput("tie_model_idx", 32'(eIdx), 32'd0);
    applyStimulus(1'b0, bmp, 0, eScore, 1'b1);
    waitIdle0(400);
    modelBest(1'b1, bmp, eIdx, eScore);
    applyStimulus(1'b1, bmp, 0, eScore, 1'b1);
    waitIdle0(400);

    // Random templates and bitmaps checked against the reference score.
    for (int t = 0; t < N0; t++)
      for (int c = 0; c < W0; c++)
        writeTemplate(t, c, randCol(), 1'b1);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W0; c++) bmp[c*H0 +: H0] = randCol();
      modelBest(1'(r % 2), bmp, eIdx, eScore);
      $display("[TB] random run %0d: expect idx %0d score %0d", r, eIdx, eScore);
      applyStimulus(1'(r % 2), bmp, eIdx, eScore, 1'b1);
      waitIdle0(400);
    end

    // Small instance: template 1 equals the bitmap, template 0 its inverse.
    sbmp = {$urandom} | 32'd1;
    for (int c = 0; c < W1; c++) begin
      scol = sbmp[c*H1 +: H1];
      writeTemplateSmall(1, c, scol);
      writeTemplateSmall(0, c, ~scol);
    end
    $display("[TB] small instance runs");
    applySmall(1'b0, sbmp, 1, 32);
    waitIdle1(40);
    applySmall(1'b1, sbmp, 1, $countones(sbmp));
    waitIdle1(40);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
